branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Dynamic conditional-branch predictor feeding the ID-stage 'predict' input; replaces the static predict bit.
//  Table of 2-bit saturating counters, indexed by PC (bimodal) or PC XOR global history (gshare, MODE=1).
//  Lookup is combinational on the IF/ID PC. Update arrives from EX when a branch resolves.
//  The lookup index travels down the pipe and returns with the update, so gshare trains the entry it read.
// PARAMETERS
//  XLEN      32     PC width
//  ENTRIES   64     counter count; power of two, >=4
//  GHR_BITS  6      global history length; 1..log2(ENTRIES)
//  MODE      0      0 = bimodal, 1 = gshare
//  CNT_INIT  2'b01  counter reset value (weakly not-taken)
// PORTS
//  clk            in   1          clock
//  rstn           in   1          synchronous reset, active low
//  pc_IF          in   XLEN       PC of instruction in decode
//  predict        out  1          1 = predict taken (counter[1])
//  pred_idx       out  IW         table index used (IW=log2(ENTRIES)); piped to EX
//  busy           out  1          table init in progress
//  upd_valid      in   1          EX resolved a conditional branch this cycle
//  upd_idx        in   IW         pred_idx carried with that branch
//  upd_taken      in   1          actual outcome
//  upd_mispredict in   1          prediction was wrong (counts only)
//  stat_branches  out  32         resolved branches since reset
//  stat_mispred   out  32         mispredictions since reset
// BEHAVIOUR
//  Index:
//   - MODE0: idx = pc_IF[IW+1:2].
//   - MODE1: idx = pc_IF[IW+1:2] ^ {zero-pad, ghr}.
//  FSM, states INIT and RUN:
//   - rstn=0 (sampled at posedge): enter INIT; wptr=0; ghr=0; stat_* = 0.
//   - INIT: write CNT_INIT to entry wptr each cycle, wptr++.
//   - INIT exits to RUN after the cycle that writes entry ENTRIES-1.
//   - INIT takes exactly ENTRIES cycles; busy=1 throughout.
//  During INIT: predict=0, pred_idx=0, upd_valid ignored (no counter, ghr or stat change).
//  Reset outputs:
//   - predict=0, pred_idx=0, busy=1, stat_*=0.
//   - In the cycle after a reset edge, busy=1 and wptr=0.
//  RUN lookup: predict = cnt[idx][1], pure combinational, same cycle as pc_IF.
//  RUN update (upd_valid=1), at posedge:
//   - cnt[upd_idx] += 1 if upd_taken, saturating at 3.
//   - cnt[upd_idx] -= 1 if not taken, saturating at 0.
//   - ghr <= {ghr[GHR_BITS-2:0], upd_taken} in both modes; ghr is only used by MODE1.
//   - stat_branches++; stat_mispred++ if upd_mispredict. Both wrap modulo 2^32.
//  Simultaneous lookup and update of the same entry: lookup returns the pre-update value (no bypass).
//   - ghr update is likewise visible from the next cycle only.
//  Reset mid-INIT or mid-RUN restarts INIT from wptr=0. Counters, ghr and stats are fully reinitialised.
//  Update latency: one cycle. No stall/flush inputs; caller gates upd_valid for killed branches.
//  Only upd_idx is used for training, never the PC, so wrong-path lookups have no side effects.
// TESTING
//  1. Reset, ENTRIES=64: busy=1 for exactly 64 cycles. Then predict=0 for every pc_IF; stat_*=0.
//  2. MODE0, pc=0x40 (idx 16), two taken updates: predict 0 -> 1; two more taken keep 1 (cnt=3).
//     Then one not-taken update: cnt=2, predict stays 1.
//  3. MODE0, four not-taken updates on idx 5: cnt saturates at 0.
//     One taken update -> cnt=1, predict=0; a second taken -> predict=1.
//  4. MODE1, GHR_BITS=2, updates T,T on idx 0: ghr=2'b11.
//     Lookup pc=0x0 gives pred_idx=3; lookup pc=0xC gives pred_idx=0.
//  5. Same-cycle update (taken, idx 7, cnt=1) and lookup of idx 7: predict=0 that cycle, 1 the next.
//  6. Ten updates with 3 mispredicts -> stat_branches=10, stat_mispred=3.
//     Assert rstn=0 mid-RUN -> stats=0, busy=1, all counters back to CNT_INIT.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Dynamic conditional-branch predictor. A table of 2-bit
//                saturating counters is indexed by PC (bimodal) or by
//                PC XOR global history (gshare). After reset the table is
//                filled with CNT_INIT, one entry per cycle. Lookup is
//                combinational. Training uses only the index that travelled
//                down the pipe with the branch.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_predictor #(
  parameter int         XLEN     = 32,
  parameter int         ENTRIES  = 64,
  parameter int         GHR_BITS = 6,
  parameter int         MODE     = 0,
  parameter logic [1:0] CNT_INIT = 2'b01,
  localparam int        IW       = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] pc_IF,
  output logic            predict,
  output logic [IW-1:0]   pred_idx,
  output logic            busy,
  input  logic            upd_valid,
  input  logic [IW-1:0]   upd_idx,
  input  logic            upd_taken,
  input  logic            upd_mispredict,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     wptr_q, wptr_d;
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [GHR_BITS-1:0] ghr_shift;
  logic [31:0]       stat_br_q, stat_br_d;
  logic [31:0]       stat_mp_q, stat_mp_d;
  logic [1:0]        cnt_q [ENTRIES];
  logic [1:0]        upd_cnt_d;
  logic [IW-1:0]     ghr_ext;
  logic [IW-1:0]     lookup_idx;
  logic              run_upd;

  // PC bits outside the index field carry no prediction information.
  logic w_pc_unused;
  assign w_pc_unused = ^{pc_IF[XLEN-1:IW+2], pc_IF[1:0]};

  // History shift: newest outcome enters at bit 0.
  generate
    if (GHR_BITS == 1) begin : g_ghr_one
      assign ghr_shift = upd_taken;
    end else begin : g_ghr_shift
      assign ghr_shift = {ghr_q[GHR_BITS-2:0], upd_taken};
    end
  endgenerate

  assign run_upd = (state_q == ST_RUN) && upd_valid;

  // Index generation, history zero-extended to the index width.
  always_comb begin
    ghr_ext                 = '0;
    ghr_ext[GHR_BITS-1:0]   = ghr_q;
    lookup_idx              = pc_IF[IW+1:2];
    if (MODE == 1) begin
      lookup_idx = pc_IF[IW+1:2] ^ ghr_ext;
    end
  end

  // Lookup outputs are forced quiet while the table is being filled.
  always_comb begin
    busy     = (state_q == ST_INIT);
    predict  = 1'b0;
    pred_idx = '0;
    if (state_q == ST_RUN) begin
      predict  = cnt_q[lookup_idx][1];
      pred_idx = lookup_idx;
    end
  end

  // Saturating increment/decrement of the entry being trained.
  always_comb begin
    upd_cnt_d = cnt_q[upd_idx];
    if (upd_taken) begin
      if (cnt_q[upd_idx] != 2'b11) upd_cnt_d = cnt_q[upd_idx] + 2'b01;
    end else begin
      if (cnt_q[upd_idx] != 2'b00) upd_cnt_d = cnt_q[upd_idx] - 2'b01;
    end
  end

  // FSM next state plus history, fill pointer and statistics.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    ghr_d     = ghr_q;
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    case (state_q)
      ST_INIT: begin
        wptr_d = wptr_q + 1'b1;
        if (wptr_q == IW'(ENTRIES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (upd_valid) begin
          ghr_d     = ghr_shift;
          stat_br_d = stat_br_q + 32'd1;
          if (upd_mispredict) stat_mp_d = stat_mp_q + 32'd1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_INIT;
      wptr_q    <= '0;
      ghr_q     <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      ghr_q     <= ghr_d;
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  // Counter table: filled during INIT, trained by resolved branches in RUN.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (state_q == ST_INIT) begin
        cnt_q[wptr_q] <= CNT_INIT;
      end else if (run_upd) begin
        cnt_q[upd_idx] <= upd_cnt_d;
      end
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Bench for branch_predictor. A bimodal instance and a gshare
//                instance (2-bit history) share all inputs; each is compared
//                with its own table model held as plain integer arrays.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_predictor;

  localparam int N  = 64;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   pc;
  logic          upd_valid;
  logic [IW-1:0] upd_idx;
  logic          upd_taken;
  logic          upd_mis;

  logic          p0, p1, b0, b1;
  logic [IW-1:0] pi0, pi1;
  logic [31:0]   sb0, sm0, sb1, sm1;

  int errors = 0;
  int checks = 0;

  // Reference state
  int          m0 [N];
  int          m1 [N];
  int          mghr;
  logic [31:0] mbr, mmp;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(N), .GHR_BITS(6), .MODE(0)) u0 (
    .clk(clk), .rstn(rstn), .pc_IF(pc), .predict(p0), .pred_idx(pi0),
    .busy(b0), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_mispredict(upd_mis),
    .stat_branches(sb0), .stat_mispred(sm0));

  branch_predictor #(.ENTRIES(N), .GHR_BITS(2), .MODE(1)) u1 (
    .clk(clk), .rstn(rstn), .pc_IF(pc), .predict(p1), .pred_idx(pi1),
    .busy(b1), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_mispredict(upd_mis),
    .stat_branches(sb1), .stat_mispred(sm1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx0(input logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic int idx1(input logic [31:0] a);
    return int'(((a >> 2) ^ mghr) % N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m0[i] = 1; m1[i] = 1; end
    mghr = 0; mbr = 0; mmp = 0;
  endtask

  task automatic model_update(input int i, input bit t, input bit mis);
    if (t) begin
      if (m0[i] < 3) m0[i]++;
      if (m1[i] < 3) m1[i]++;
    end else begin
      if (m0[i] > 0) m0[i]--;
      if (m1[i] > 0) m1[i]--;
    end
    mghr = ((mghr << 1) | int'(t)) % 4;
    mbr++;
    if (mis) mmp++;
  endtask

  // One resolved branch in RUN.
  task automatic upd(input int i, input bit t, input bit mis);
    upd_valid = 1'b1; upd_idx = IW'(i); upd_taken = t; upd_mis = mis;
    tick();
    model_update(i, t, mis);
    upd_valid = 1'b0;
    #1;
  endtask

  // Reset, then count busy cycles until the fill completes; updates offered
  // during the fill must be ignored.
  task automatic do_reset(input string tag);
    int n;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    model_reset();
    #1;
    chk({tag, "_busy"}, 32'(b0), 32'd1);
    chk({tag, "_pred"}, 32'(p0), 32'd0);
    chk({tag, "_pidx"}, 32'(pi1), 32'd0);
    chk({tag, "_sbr"},  sb0, 32'd0);
    chk({tag, "_smp"},  sm1, 32'd0);
    n = 0;
    upd_valid = 1'b1; upd_idx = 6'd3; upd_taken = 1'b1; upd_mis = 1'b1;
    while (b0 && n < 200) begin
      n++;
      tick();
    end
    upd_valid = 1'b0;
    #1;
    chk({tag, "_init_cycles"}, 32'(n), 32'(N));
    chk({tag, "_busy_done"}, 32'(b1), 32'd0);
    chk({tag, "_sbr_after"}, sb1, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; pc = '0; upd_valid = 1'b0; upd_idx = '0;
    upd_taken = 1'b0; upd_mis = 1'b0;
    model_reset();
    tick();

    // 1. reset and fill
    do_reset("rst1");
    for (int i = 0; i < N; i++) begin
      pc = 32'(i * 4); #1;
      chk("t1_pred0", 32'(p0), 32'd0);
      chk("t1_pred1", 32'(p1), 32'd0);
    end

    // 2. bimodal saturation up at idx 16
    pc = 32'h40; #1;
    chk("t2_start", 32'(p0), 32'd0);
    chk("t2_pidx", 32'(pi0), 32'd16);
    upd(16, 1, 0); chk("t2_T1", 32'(p0), 32'd1);
    upd(16, 1, 0); chk("t2_T2", 32'(p0), 32'd1);
    upd(16, 1, 0); chk("t2_T3", 32'(p0), 32'd1);
    upd(16, 1, 0); chk("t2_T4", 32'(p0), 32'd1);
    upd(16, 0, 1); chk("t2_N1", 32'(p0), 32'd1);
    upd(16, 0, 0); chk("t2_N2", 32'(p0), 32'd0);

    // 3. bimodal saturation down at idx 5
    pc = 32'h14; #1;
    for (int k = 0; k < 4; k++) upd(5, 0, 0);
    chk("t3_sat0", 32'(p0), 32'd0);
    upd(5, 1, 0); chk("t3_T1", 32'(p0), 32'd0);
    upd(5, 1, 0); chk("t3_T2", 32'(p0), 32'd1);

    // 4. gshare history
    upd(0, 1, 0);
    upd(0, 1, 0);
    pc = 32'h0; #1; chk("t4_idx_pc0", 32'(pi1), 32'd3);
    pc = 32'hC; #1; chk("t4_idx_pcC", 32'(pi1), 32'd0);
    chk("t4_idx_model", 32'(pi1), 32'(idx1(pc)));

    // 5. same-cycle update and lookup, no bypass
    pc = 32'h1C;
    upd_valid = 1'b1; upd_idx = 6'd7; upd_taken = 1'b1; upd_mis = 1'b0;
    #1;
    chk("t5_same_cycle", 32'(p0), 32'd0);
    tick();
    model_update(7, 1, 0);
    upd_valid = 1'b0;
    #1;
    chk("t5_next_cycle", 32'(p0), 32'd1);

    // 6. statistics from a clean start
    do_reset("rst2");
    for (int i = 0; i < 10; i++) upd(i % 8, bit'(i % 2), i < 3);
    chk("t6_sbr", sb0, 32'd10);
    chk("t6_smp", sm0, 32'd3);
    chk("t6_sbr_model", sb1, mbr);

    // Random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      pc        = $urandom;
      upd_valid = 1'($urandom_range(0, 1));
      upd_idx   = IW'($urandom_range(0, 7));
      upd_taken = 1'($urandom_range(0, 1));
      upd_mis   = 1'($urandom_range(0, 1));
      if ((c % 3) == 0) pc = {pc[31:5], 5'b0} & 32'h0000_001C;
      #1;
      chk("rnd_p0",   32'(p0),  32'(m0[idx0(pc)] >= 2));
      chk("rnd_pi1",  32'(pi1), 32'(idx1(pc)));
      chk("rnd_p1",   32'(p1),  32'(m1[idx1(pc)] >= 2));
      tick();
      if (upd_valid) model_update(int'(upd_idx), upd_taken, upd_mis);
    end
    upd_valid = 1'b0;
    #1;
    chk("rnd_sbr", sb0, mbr);
    chk("rnd_smp", sm1, mmp);

    // Reset mid-RUN restores everything
    do_reset("rst3");
    pc = 32'h0; #1;
    chk("rst3_ghr_idx", 32'(pi1), 32'd0);
    for (int i = 0; i < 8; i++) begin
      pc = 32'(i * 4); #1;
      chk("rst3_pred", 32'(p0), 32'd0);
    end
    pc = 32'h4; #1;
    upd(1, 1, 0);
    chk("rst3_cnt_init", 32'(p0), 32'd1);
    chk("rst3_stats", sb0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
